// File: rtl/fma_share_pkg.sv
// Shared constants and tag type for the FMA-array sharing arbiter.
package fma_share_pkg;

   localparam int BW_FP    = 17;
   localparam int VALUE_MK = 128;
   localparam int MODE_W   = 5;
   localparam logic [MODE_W-1:0] MODE_IDLE = 5'd0;

   // Sized for the largest supported requester count (8), so one tag type serves every build.
   localparam int TAG_ID_W = 3;

   typedef struct packed {
      logic                vld;
      logic [TAG_ID_W-1:0] id;
   } fma_tag_t;

endpackage

// File: rtl/rr_arb_core.sv
// One-hot round-robin pick plus pointer register.
// FMA_SHARE_ARB_DECODE_PRIO_EN: in decode phase requester 0 wins whenever it asks.
module rr_arb_core #(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               state_decode,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    win_id,
   output logic               win_vld
);

   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] cand;

   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      gnt     = '0;
      win_id  = '0;
      win_vld = 1'b0;
      cand    = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = ID_W'((int'(ptr) + off) % NUM_REQ);
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win_id  = cand;
         end
      end
`ifdef FMA_SHARE_ARB_DECODE_PRIO_EN
      if (state_decode && req[0]) begin
         win_vld = 1'b1;
         win_id  = '0;
      end
`endif
      if (win_vld) gnt[win_id] = 1'b1;
   end

`ifndef FMA_SHARE_ARB_DECODE_PRIO_EN
   logic state_decode_unused;
   assign state_decode_unused = state_decode;
`endif

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ptr <= ID_W'(NUM_REQ - 1);
      else if (win_vld) ptr <= win_id;
   end

endmodule

// File: rtl/fma_share_arb.sv
// Shares one VALUE_MK-lane FMA array between NUM_REQ requesters and routes results back.
// Optional decode-phase priority for requester 0 under FMA_SHARE_ARB_DECODE_PRIO_EN.
module fma_share_arb #(
   parameter int BW_FP    = fma_share_pkg::BW_FP,
   parameter int VALUE_MK = fma_share_pkg::VALUE_MK,
   parameter int NUM_REQ  = 3,
   parameter int FMA_LAT  = 2,
   parameter int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          state_decode,
   input  logic [NUM_REQ-1:0]                            req,
   input  logic [NUM_REQ*VALUE_MK*BW_FP-1:0]             req_a,
   input  logic [NUM_REQ*VALUE_MK*BW_FP-1:0]             req_b,
   input  logic [NUM_REQ*VALUE_MK*fma_share_pkg::MODE_W-1:0] req_mode,
   output logic [NUM_REQ-1:0]                            gnt,
   output logic [VALUE_MK*BW_FP-1:0]                     a_fma,
   output logic [VALUE_MK*BW_FP-1:0]                     b_fma,
   output logic [VALUE_MK*fma_share_pkg::MODE_W-1:0]     mode_fma,
   input  logic [VALUE_MK*BW_FP-1:0]                     FMA_out,
   output logic [NUM_REQ-1:0]                            rsp_valid,
   output logic [VALUE_MK*BW_FP-1:0]                     rsp_data,
   output logic                                          busy
);

   import fma_share_pkg::*;

   localparam int OP_W = VALUE_MK * BW_FP;
   localparam int MD_W = VALUE_MK * MODE_W;

   logic [ID_W-1:0] win_id;
   logic            win_vld;
   fma_tag_t        tag_q [FMA_LAT+1];

   rr_arb_core #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .clk          (clk),
      .rst_n        (rst_n),
      .state_decode (state_decode),
      .req          (req),
      .gnt          (gnt),
      .win_id       (win_id),
      .win_vld      (win_vld)
   );

   // Idle cycles drive zero operands and MODE_IDLE so the array sees a clean no-op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_fma    <= '0;
         b_fma    <= '0;
         mode_fma <= '0;
      end else if (win_vld) begin
         a_fma    <= req_a[int'(win_id)*OP_W +: OP_W];
         b_fma    <= req_b[int'(win_id)*OP_W +: OP_W];
         mode_fma <= req_mode[int'(win_id)*MD_W +: MD_W];
      end else begin
         a_fma    <= '0;
         b_fma    <= '0;
         mode_fma <= {VALUE_MK{MODE_IDLE}};
      end
   end

   // NOTE: the tag pipe is reset because stale vld bits would emit phantom responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= FMA_LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= {win_vld, TAG_ID_W'(win_id)};
         for (int i = 1; i <= FMA_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   // The tail entry lines up with FMA_out; rsp_data keeps its last value between responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else if (tag_q[FMA_LAT].vld) begin
         rsp_valid <= NUM_REQ'(1) << tag_q[FMA_LAT].id;
         rsp_data  <= FMA_out;
      end else begin
         rsp_valid <= '0;
      end
   end

   always_comb begin
      busy = |rsp_valid;
      for (int i = 0; i <= FMA_LAT; i++) busy = busy | tag_q[i].vld;
   end

endmodule

// File: doc/fma_share_arb.md
Name: fma_share_arb

Overview:
- Shares one VALUE_MK-lane FMA array between NUM_REQ requesters. Typical requesters: ffn multiply, SiLU, RMSNorm.
- Arbitrates each cycle with round-robin, issues the winner's operands to the array, and tracks ownership of every in-flight op.
- Routes each FMA result back to the requester that issued it.
- Sits between the FFN/attention control blocks and the shared FMA datapath.

Parameters:
- BW_FP, 17, FP operand width per lane.
- VALUE_MK, 128, lanes per FMA issue.
- NUM_REQ, 3, number of requesters (2..8).
- FMA_LAT, 2, cycles from operands on a_fma/b_fma to a valid FMA_out.
- ID_W, $clog2(NUM_REQ), requester id width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- state_decode  input  1  decode-phase flag; used only by the optional feature.
- req  input  NUM_REQ  per-requester issue request; level, held until granted.
- req_a  input  NUM_REQ*VALUE_MK*BW_FP  A operands; requester i occupies slice i.
- req_b  input  NUM_REQ*VALUE_MK*BW_FP  B operands.
- req_mode  input  NUM_REQ*VALUE_MK*5  per-lane op mode.
- gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as req.
- a_fma  output  VALUE_MK*BW_FP  registered operand A to the array.
- b_fma  output  VALUE_MK*BW_FP  registered operand B.
- mode_fma  output  VALUE_MK*5  registered mode.
- FMA_out  input  VALUE_MK*BW_FP  array result.
- rsp_valid  output  NUM_REQ  one-hot one-cycle result strobe.
- rsp_data  output  VALUE_MK*BW_FP  registered result, valid while rsp_valid≠0.
- busy  output  1  high while any op is in flight or a response is pending.

Behaviour:
- Reset values: a_fma, b_fma, mode_fma, rsp_data, rsp_valid and busy are 0. Round-robin pointer resets to NUM_REQ-1, so requester 0 wins first. Tag pipe is cleared.
- Arbitration, cycle t:
  - Search starts at pointer+1 and wraps modulo NUM_REQ; the first asserted req wins.
  - gnt[winner]=1 in cycle t. At most one gnt bit is set. gnt=0 when req=0.
  - Pointer <= winner at the clock edge ending cycle t. Pointer is unchanged when nothing is granted.
  - A requester may change operands or drop req from cycle t+1 onward.
- Issue, cycle t+1:
  - a_fma/b_fma/mode_fma hold the winner's slices captured at t.
  - In any cycle without a grant at t, they are driven to 0, and mode 0 means idle.
  - Back-to-back issue every cycle is allowed; there is no bubble.
- Tag pipe:
  - Depth FMA_LAT+1, each entry {vld, id}.
  - The entry for the issue at t+1 reaches the tail in cycle t+1+FMA_LAT, when FMA_out is valid.
  - On that clock edge: rsp_data <= FMA_out and rsp_valid[id] <= 1. rsp_valid is 0 otherwise.
- Latency: gnt in cycle t gives rsp_valid in cycle t+2+FMA_LAT, which is 4 cycles with defaults.
- rsp_data holds its last value until the next response.
- Throughput: one result per cycle. Response order per requester equals issue order.
- busy = |tag-pipe vld | |rsp_valid. busy does not depend on req.
- Boundary conditions:
  - Single requester holding req continuously: granted every cycle.
  - All requesters asserted: grants rotate 0,1,…,NUM_REQ-1,0,… with each granted exactly once per NUM_REQ cycles.
  - A requester deasserting req in the same cycle it would have won: not granted; the next in rotation wins.
  - req bits at index ≥NUM_REQ do not exist; a width mismatch is an elaboration error.
  - Reset mid-operation: in-flight ops are discarded; no rsp_valid is produced for them after reset release.
- No backpressure: requesters must accept rsp_valid whenever it fires.

Optional Feature:
- Macro: FMA_SHARE_ARB_DECODE_PRIO_EN.
- Defined: when state_decode=1 and req[0]=1, requester 0 wins regardless of the pointer, and the pointer is set to 0. With state_decode=0, pure round-robin applies.
- Not defined: state_decode is ignored (port kept) and arbitration is pure round-robin.

Decomposition:
- Package fma_share_pkg holds:
  - BW_FP, VALUE_MK, the mode width constant MODE_W=5, MODE_IDLE=5'd0.
  - typedef fma_tag_t as a struct {logic vld; logic [ID_W-1:0] id}.
- One sub-module, rr_arb_core: combinational one-hot round-robin pick from req and pointer, plus the pointer register. The top instantiates it, adds the operand mux/registers, tag pipe and response register.

Test Plan:
- Reset, then req=3'b001 for one cycle with a=1.0 and b=2.0 in all lanes, mode=MUL:
  - gnt=001 in that cycle.
  - a_fma/b_fma hold the operands one cycle later.
  - rsp_valid=001 four cycles after gnt, with rsp_data equal to the model FMA_out.
  - busy drops afterwards.
- req=3'b111 held for 9 cycles:
  - gnt sequence 001,010,100 repeated three times.
  - Nine responses tagged in the same order.
  - a_fma is nonzero every issue cycle.
- req=3'b101 held: gnt alternates 001,100. Requester 1 never gets rsp_valid.
- rst_n pulsed low two cycles after a grant: all outputs 0 immediately. No rsp_valid for that op after release. First grant after release goes to requester 0.
- With the macro defined, state_decode=1 and req=3'b111 for 4 cycles: gnt=001 every cycle. Then state_decode=0: next grant is 010.
- Idle cycles between grants: a_fma, b_fma and mode_fma are 0 in the cycle after each non-grant cycle.
